// File: rtl/tpose_pkg.sv
// Shared defaults and beat-count helper for the multi-lane transpose buffer.
package tpose_pkg;

   localparam int DEF_DATA_WIDTH = 8;
   localparam int DEF_BLK_DIM    = 8;
   localparam int DEF_LANES      = 2;

   function automatic int calc_beats(input int blk_dim, input int lanes);
      return (blk_dim * blk_dim) / lanes;
   endfunction

endpackage

// File: rtl/tpose_addr_gen.sv
// Maps a beat index to per-lane element addresses (row*BLK_DIM + col) in row- or column-major order.
// Purely combinational; no state, no backpressure.
module tpose_addr_gen import tpose_pkg::*; #(
   parameter int BLK_DIM = DEF_BLK_DIM,
   parameter int LANES   = DEF_LANES,
   localparam int BEATS  = calc_beats(BLK_DIM, LANES),
   localparam int BW     = $clog2(BEATS),
   localparam int SW     = $clog2(BLK_DIM),
   localparam int AW     = 2 * SW
) (
   input  logic [BW-1:0]       beat,
   input  logic                mode,
   output logic [LANES*AW-1:0] addr
);

   localparam int LW = $clog2(LANES);

   logic [AW-1:0] lin;
   logic [SW-1:0] major;
   logic [SW-1:0] minor;

   // k*LANES splits into the block-side index (major) and the lane-aligned offset (minor)
   assign lin   = AW'(beat) << LW;
   assign major = lin[AW-1:SW];
   assign minor = lin[SW-1:0];

   always_comb begin
      addr = '0;
      for (int i = 0; i < LANES; i++) begin
         logic [SW-1:0] mi;
         mi = minor + SW'(i);
         addr[i*AW +: AW] = mode ? {mi, major} : {major, mi};
      end
   end

endmodule

// File: rtl/multi_lane_transpose_buf.sv
// Ping-pong BLK_DIM x BLK_DIM block buffer; per-block transpose or pass-through; TPOSE_LAST_EN adds o_last.
// Output registered, loaded the cycle after a page fills; writes stall while both pages are full.
module multi_lane_transpose_buf import tpose_pkg::*; #(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int BLK_DIM    = DEF_BLK_DIM,
   parameter int LANES      = DEF_LANES
) (
   input  logic                        i_clk,
   input  logic                        i_resetn,
   input  logic                        i_wvalid,
   output logic                        o_wready,
   input  logic [LANES*DATA_WIDTH-1:0] i_wdata,
   input  logic                        i_transpose,
   output logic                        o_rvalid,
   input  logic                        i_rready,
   output logic [LANES*DATA_WIDTH-1:0] o_rdata
`ifdef TPOSE_LAST_EN
   ,
   output logic                        o_last
`endif
);

   localparam int BEATS = calc_beats(BLK_DIM, LANES);
   localparam int BW    = $clog2(BEATS);
   localparam int AW    = 2 * $clog2(BLK_DIM);
   localparam int ELEMS = BLK_DIM * BLK_DIM;
   localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);

   logic [DATA_WIDTH-1:0] mem [2][ELEMS];

   logic [BW-1:0]               wcnt;
   logic [BW-1:0]               rcnt;
   logic                        wpage;
   logic                        rpage;
   logic [1:0]                  full;
   logic [1:0]                  mode;
   logic                        w_acc;
   logic                        r_load;
   logic [LANES*AW-1:0]         waddr;
   logic [LANES*AW-1:0]         raddr;
   logic [LANES*DATA_WIDTH-1:0] rd_beat;

   assign o_wready = !full[wpage];
   assign w_acc    = i_wvalid && o_wready;
   assign r_load   = full[rpage] && (!o_rvalid || i_rready);

   tpose_addr_gen #(
      .BLK_DIM (BLK_DIM),
      .LANES   (LANES)
   ) u_waddr (
      .beat    (wcnt),
      .mode    (1'b0),
      .addr    (waddr)
   );

   tpose_addr_gen #(
      .BLK_DIM (BLK_DIM),
      .LANES   (LANES)
   ) u_raddr (
      .beat    (rcnt),
      .mode    (mode[rpage]),
      .addr    (raddr)
   );

   // Storage is deliberately not reset; FULL flags gate every read.
   always_ff @(posedge i_clk) begin
      if (w_acc) begin
         for (int i = 0; i < LANES; i++) begin
            mem[wpage][waddr[i*AW +: AW]] <= i_wdata[i*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

   always_comb begin
      rd_beat = '0;
      for (int i = 0; i < LANES; i++) begin
         rd_beat[i*DATA_WIDTH +: DATA_WIDTH] = mem[rpage][raddr[i*AW +: AW]];
      end
   end

   // Set and clear can land in the same cycle only on opposite pages.
   always_ff @(posedge i_clk) begin
      if (!i_resetn) begin
         wcnt     <= '0;
         rcnt     <= '0;
         wpage    <= 1'b0;
         rpage    <= 1'b0;
         full     <= '0;
         mode     <= '0;
         o_rvalid <= 1'b0;
         o_rdata  <= '0;
`ifdef TPOSE_LAST_EN
         o_last   <= 1'b0;
`endif
      end else begin
         if (w_acc) begin
            if (wcnt == '0) begin
               mode[wpage] <= i_transpose;
            end
            if (wcnt == LAST_BEAT) begin
               wcnt        <= '0;
               full[wpage] <= 1'b1;
               wpage       <= ~wpage;
            end else begin
               wcnt <= wcnt + BW'(1);
            end
         end

         if (r_load) begin
            o_rvalid <= 1'b1;
            o_rdata  <= rd_beat;
`ifdef TPOSE_LAST_EN
            o_last   <= (rcnt == LAST_BEAT);
`endif
            if (rcnt == LAST_BEAT) begin
               rcnt        <= '0;
               full[rpage] <= 1'b0;
               rpage       <= ~rpage;
            end else begin
               rcnt <= rcnt + BW'(1);
            end
         end else if (i_rready) begin
            o_rvalid <= 1'b0;
         end
      end
   end

endmodule
